// File: rtl/gost_cbc_feeder.sv
`default_nettype none
// ============================================================================
// Module   : gost_cbc_feeder
// Brief    : Packs a plaintext byte stream MSB-first into 128-bit blocks,
//            pads the final block (PKCS#7 or zero-fill) and launches each
//            block into a CBC cipher stage, holding it until completion.
// Revision : 1.0 - initial release
// ============================================================================
module gost_cbc_feeder #(
  parameter bit PAD_ENABLE = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  input  logic         byte_last,
  output logic         byte_ready,
  output logic [127:0] block_out,
  output logic         start_trigger,
  input  logic         done_block,
  output logic         busy,
  output logic [31:0]  blocks_sent
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    COLLECT     = 3'd1,
    PAD         = 3'd2,
    LAUNCH      = 3'd3,
    WAIT_CIPHER = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic           pad_pending_q, pad_pending_d;
  logic [127:0]   block_q, block_d;
  logic [31:0]    blocks_sent_q, blocks_sent_d;
  logic [7:0]     pad_byte;

  // PKCS#7 value is the number of bytes still missing after position idx.
  assign pad_byte = PAD_ENABLE ? {4'd0, 4'hF - idx_q} : 8'h00;

  // Outputs decoded straight from state so reset clears them immediately.
  assign byte_ready    = (state_q == COLLECT);
  assign start_trigger = (state_q == LAUNCH);
  assign busy          = (state_q == LAUNCH) || (state_q == WAIT_CIPHER);
  assign block_out     = block_q;
  assign blocks_sent   = blocks_sent_q;

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= 4'd0;
      pad_pending_q <= 1'b0;
      block_q       <= '0;
      blocks_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pad_pending_q <= pad_pending_d;
      block_q       <= block_d;
      blocks_sent_q <= blocks_sent_d;
    end
  end

  // Next-state and datapath update; block_q only changes in COLLECT, PAD and
  // on the pad-block reload, so it stays frozen while the cipher runs.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pad_pending_d = pad_pending_q;
    block_d       = block_q;
    blocks_sent_d = blocks_sent_q;
    case (state_q)
      IDLE: begin
        idx_d   = 4'd0;
        state_d = COLLECT;
      end
      COLLECT: begin
        if (byte_valid) begin
          // Byte k lands at bit offset 8*(15-k); ~idx equals 15-idx.
          block_d[{~idx_q, 3'b000} +: 8] = byte_in;
          if (idx_q == 4'hF) begin
            idx_d   = 4'd0;
            state_d = LAUNCH;
            if (byte_last && PAD_ENABLE) pad_pending_d = 1'b1;
          end else if (byte_last) begin
            // idx is kept at the last byte's position so PAD knows the fill.
            state_d = PAD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PAD: begin
        for (int p = 0; p < 16; p++) begin
          if (4'(p) > idx_q) block_d[8*(15-p) +: 8] = pad_byte;
        end
        idx_d   = 4'd0;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        blocks_sent_d = blocks_sent_q + 32'd1;
        state_d       = WAIT_CIPHER;
      end
      WAIT_CIPHER: begin
        if (done_block) begin
          if (pad_pending_q) begin
            // Message ended on a block boundary: send a full pad block.
            block_d       = {16{8'h10}};
            pad_pending_d = 1'b0;
            state_d       = LAUNCH;
          end else begin
            idx_d   = 4'd0;
            state_d = COLLECT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gost_cbc_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gost_cbc_feeder
// Brief    : Scoreboard bench for gost_cbc_feeder (PAD_ENABLE=1 and =0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gost_cbc_feeder;

  typedef struct {
    logic [127:0] blk;
    logic [31:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  // Instance with PKCS#7 padding
  logic [7:0]   in1 = 8'h00;
  logic         val1 = 1'b0, last1 = 1'b0, done1 = 1'b0;
  logic         rdy1, st1, busy1;
  logic [127:0] blk1;
  logic [31:0]  cnt1;

  // Instance with zero-fill
  logic [7:0]   in0 = 8'h00;
  logic         val0 = 1'b0, last0 = 1'b0, done0 = 1'b0;
  logic         rdy0, st0, busy0;
  logic [127:0] blk0;
  logic [31:0]  cnt0;

  int checks = 0;
  int failures = 0;
  exp_t q1[$];
  exp_t q0[$];

  always #5 clk = ~clk;

  gost_cbc_feeder #(.PAD_ENABLE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .byte_in(in1), .byte_valid(val1),
    .byte_last(last1), .byte_ready(rdy1), .block_out(blk1),
    .start_trigger(st1), .done_block(done1), .busy(busy1),
    .blocks_sent(cnt1)
  );

  gost_cbc_feeder #(.PAD_ENABLE(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .byte_in(in0), .byte_valid(val0),
    .byte_last(last0), .byte_ready(rdy0), .block_out(blk0),
    .start_trigger(st0), .done_block(done0), .busy(busy0),
    .blocks_sent(cnt0)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send1(input logic [7:0] b, input logic l);
    int n = 0;
    in1 = b; last1 = l; val1 = 1'b1;
    while (!rdy1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send1_timeout", 128'(n), 128'd0);
    @(posedge clk); #1;
    val1 = 1'b0; last1 = 1'b0;
  endtask

  task automatic send0(input logic [7:0] b, input logic l);
    int n = 0;
    in0 = b; last0 = l; val0 = 1'b1;
    while (!rdy0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send0_timeout", 128'(n), 128'd0);
    @(posedge clk); #1;
    val0 = 1'b0; last0 = 1'b0;
  endtask

  task automatic cipher1();
    int n = 0;
    while (!busy1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("cipher1_busy_timeout", 128'(n), 128'd0);
    repeat (3) @(negedge clk);
    done1 = 1'b1;
    @(negedge clk);
    done1 = 1'b0;
  endtask

  task automatic cipher0();
    int n = 0;
    while (!busy0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("cipher0_busy_timeout", 128'(n), 128'd0);
    repeat (3) @(negedge clk);
    done0 = 1'b1;
    @(negedge clk);
    done0 = 1'b0;
  endtask

  // Monitor for the padded instance: every launch must match the queue head,
  // the counter must show the new value next cycle and the block must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (st1) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL launch1_unexpected: got block %h expected no launch", blk1);
        end else begin
          e = q1.pop_front();
          chk("launch1_block", blk1, e.blk);
          @(negedge clk);
          chk("launch1_count", 128'(cnt1), 128'(e.cnt));
          chk("launch1_hold", blk1, e.blk);
        end
      end
    end
  end

  // Monitor for the zero-fill instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (st0) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL launch0_unexpected: got block %h expected no launch", blk0);
        end else begin
          e = q0.pop_front();
          chk("launch0_block", blk0, e.blk);
          @(negedge clk);
          chk("launch0_count", 128'(cnt0), 128'(e.cnt));
        end
      end
    end
  end

  // Global time bound
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #1;
    chk("rst_block", blk1, 128'd0);
    chk("rst_outs", {125'd0, rdy1, st1, busy1}, 128'd0);
    chk("rst_count", 128'(cnt1), 128'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rdy_before_edges", 128'(rdy1), 128'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("rdy_after_two_edges", 128'(rdy1), 128'd1);

    // Full block with last on byte 16 -> data block then pad block
    q1.push_back('{128'h000102030405060708090A0B0C0D0E0F, 32'd1});
    q1.push_back('{{16{8'h10}}, 32'd2});
    for (int i = 0; i < 16; i++) send1(8'(i), i == 15);
    chk("full_latency", 128'(st1), 128'd1);
    cipher1();
    cipher1();

    // Partial block: PAD then LAUNCH, PKCS#7 fill of 0x0D
    q1.push_back('{128'hAABBCC0D0D0D0D0D0D0D0D0D0D0D0D0D, 32'd3});
    send1(8'hAA, 1'b0);
    send1(8'hBB, 1'b0);
    send1(8'hCC, 1'b1);
    chk("partial_lat_pad", 128'(st1), 128'd0);
    @(posedge clk); #1;
    chk("partial_lat_launch", 128'(st1), 128'd1);

    // Backpressure while the cipher runs
    @(negedge clk);
    in1 = 8'h55; val1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready_low", 128'(rdy1), 128'd0);
      chk("bp_block_stable", blk1, 128'hAABBCC0D0D0D0D0D0D0D0D0D0D0D0D0D);
    end
    val1 = 1'b0;
    cipher1();

    // Following block must start cleanly at byte position 0
    q1.push_back('{128'h404142434445464748494A4B4C4D4E4F, 32'd4});
    for (int i = 0; i < 16; i++) send1(8'h40 + 8'(i), 1'b0);
    cipher1();

    // Zero-fill instance: partial then full block, no extra pad block
    q0.push_back('{128'hAABBCC00000000000000000000000000, 32'd1});
    send0(8'hAA, 1'b0);
    send0(8'hBB, 1'b0);
    send0(8'hCC, 1'b1);
    cipher0();
    q0.push_back('{128'h000102030405060708090A0B0C0D0E0F, 32'd2});
    for (int i = 0; i < 16; i++) send0(8'(i), i == 15);
    cipher0();
    repeat (10) @(negedge clk);
    chk("zf_count", 128'(cnt0), 128'd2);
    chk("zf_idle_ready", 128'(rdy0), 128'd1);

    // Reset in the middle of collection
    for (int i = 0; i < 7; i++) send1(8'h20 + 8'(i), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_block", blk1, 128'd0);
    chk("mid_rst_outs", {125'd0, rdy1, st1, busy1}, 128'd0);
    chk("mid_rst_count", 128'(cnt1), 128'd0);
    chk("mid_rst_ready0", 128'(rdy0), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    q1.push_back('{128'h303132333435363738393A3B3C3D3E3F, 32'd1});
    for (int i = 0; i < 16; i++) send1(8'h30 + 8'(i), 1'b0);
    cipher1();

    // Counter wrap
    @(negedge clk);
    force dut.blocks_sent_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.blocks_sent_q;
    q1.push_back('{128'h770F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 32'd0});
    send1(8'h77, 1'b1);
    cipher1();

    repeat (10) @(negedge clk);
    chk("q1_drained", 128'(q1.size()), 128'd0);
    chk("q0_drained", 128'(q0.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
